// File: rtl/channel_meter.sv
// Per-channel peak meter: attack/hold/decay peak magnitude, 8-segment bargraph and held clip LED.
// Define CHANNEL_METER_CLIP_EN to compile in clip detection; otherwise clip_led is tied low.
`timescale 1ns/1ps

module channel_meter #(
  parameter int unsigned HOLD_SAMPLES = 24000,
  parameter int unsigned DECAY_DIV    = 48,
  parameter int unsigned DECAY_SHIFT  = 7,
  parameter int unsigned CLIP_THRESH  = 32000,
  parameter int unsigned CLIP_HOLD    = 48000
) (
  input  logic        clk_144,
  input  logic        reset_n,
  input  logic        sample_strobe,
  input  logic [15:0] sample_in,
  output logic [15:0] peak_level,
  output logic [7:0]  meter_leds,
  output logic        clip_led,
  output logic        meter_valid
);

  localparam int unsigned HoldW  = (HOLD_SAMPLES > 0) ? $clog2(HOLD_SAMPLES + 1) : 1;
  localparam int unsigned DecayW = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  typedef enum logic [1:0] {StIdle, StHold, StDecay} state_e;

  state_e              state_q, state_d;
  logic [14:0]         peak_q, peak_d;
  logic [14:0]         mag, shifted, decay_step, decayed;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic [DecayW-1:0]   decay_cnt_q, decay_cnt_d;
  logic [7:0]          leds_q, leds_d;
  logic                valid_q;

  // Saturating magnitude: -32768 has an all-zero low field and maps to 32767.
  always_comb begin
    mag = sample_in[14:0];
    if (sample_in[15]) begin
      mag = (sample_in[14:0] == '0) ? 15'h7fff : 15'(~sample_in[14:0] + 15'd1);
    end
  end

  always_comb begin
    shifted    = peak_q >> DECAY_SHIFT;
    decay_step = (shifted == '0) ? 15'd1 : shifted;
    decayed    = peak_q - decay_step;
  end

  always_comb begin
    state_d     = state_q;
    peak_d      = peak_q;
    hold_cnt_d  = hold_cnt_q;
    decay_cnt_d = decay_cnt_q;
    if (sample_strobe) begin
      if ((mag >= peak_q) && (mag != '0)) begin
        peak_d     = mag;
        hold_cnt_d = HoldW'(HOLD_SAMPLES);
        state_d    = StHold;
      end else begin
        unique case (state_q)
          StHold: begin
            if (hold_cnt_q != '0) begin
              hold_cnt_d = hold_cnt_q - HoldW'(1);
            end else begin
              peak_d      = decayed;
              decay_cnt_d = '0;
              state_d     = (decayed == '0) ? StIdle : StDecay;
            end
          end
          StDecay: begin
            if (decay_cnt_q == DecayW'(DECAY_DIV - 1)) begin
              peak_d      = decayed;
              decay_cnt_d = '0;
              if (decayed == '0) state_d = StIdle;
            end else begin
              decay_cnt_d = decay_cnt_q + DecayW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Bargraph follows the new peak so it lands in the same update.
  always_comb begin
    leds_d = leds_q;
    if (sample_strobe) begin
      for (int i = 0; i < 8; i++) begin
        leds_d[i] = (peak_d >= (15'd128 << i));
      end
    end
  end

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      peak_q      <= '0;
      hold_cnt_q  <= '0;
      decay_cnt_q <= '0;
      leds_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      peak_q      <= peak_d;
      hold_cnt_q  <= hold_cnt_d;
      decay_cnt_q <= decay_cnt_d;
      leds_q      <= leds_d;
      valid_q     <= sample_strobe;
    end
  end

`ifdef CHANNEL_METER_CLIP_EN
  localparam int unsigned ClipW = (CLIP_HOLD > 0) ? $clog2(CLIP_HOLD + 1) : 1;

  logic [ClipW-1:0] clip_cnt_q, clip_cnt_d;
  logic             clip_q, clip_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    clip_d     = clip_q;
    if (sample_strobe) begin
      if (32'(mag) >= CLIP_THRESH) begin
        clip_cnt_d = ClipW'(CLIP_HOLD);
        clip_d     = 1'b1;
      end else begin
        if (clip_cnt_q != '0) clip_cnt_d = clip_cnt_q - ClipW'(1);
        clip_d = clip_q && (clip_cnt_d != '0);
      end
    end
  end

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      clip_cnt_q <= '0;
      clip_q     <= 1'b0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
      clip_q     <= clip_d;
    end
  end

  assign clip_led = clip_q;
`else
  assign clip_led = 1'b0;
`endif

  assign peak_level  = {1'b0, peak_q};
  assign meter_leds  = leds_q;
  assign meter_valid = valid_q;

endmodule

// File: doc/channel_meter.md
# channel_meter

Per-channel peak level meter sitting directly downstream of the highpass/lowpass filter stage in the channel strip. Consumes the filter's signed 16-bit output once per sample strobe and produces an attack/hold/decay peak magnitude, an 8-segment thermometer bargraph and a held clip indicator. All outputs are registered and drive the front-panel LED driver and the control readback bus.

## Interface
Parameters:
- HOLD_SAMPLES, 24000: strobes a new peak is held before decay starts (0.5 s at 48 kHz).
- DECAY_DIV, 48: strobes per decay step while decaying (1 kHz step rate).
- DECAY_SHIFT, 7: decay step = peak >> DECAY_SHIFT, minimum 1.
- CLIP_THRESH, 32000: magnitude at or above which a sample counts as clipped.
- CLIP_HOLD, 48000: non-clipping strobes clip_led stays lit after the last clip.

Ports:
- clk_144  in  1  system clock, 3 cycles per 48 kHz sample.
- reset_n  in  1  asynchronous, active-low reset.
- sample_strobe  in  1  one-cycle pulse; sample_in valid this cycle.
- sample_in  in  16  signed filter output.
- peak_level  out  16  unsigned peak magnitude, 0..32767.
- meter_leds  out  8  thermometer bargraph, bit 0 = lowest segment.
- clip_led  out  1  held clip indicator.
- meter_valid  out  1  one-cycle pulse when outputs update.

## Operation
- Magnitude: mag = |sample_in|, saturated so -32768 gives 32767; 15-bit result zero-extended.
- FSM states IDLE (peak 0), HOLD, DECAY; evaluated only on sample_strobe.
- Attack, any state, highest priority: mag >= peak_level and mag != 0 -> peak_level <= mag, hold_cnt <= HOLD_SAMPLES, go HOLD.
- HOLD, mag < peak: hold_cnt != 0 -> decrement, peak unchanged; hold_cnt == 0 -> go DECAY, apply one decay step now, decay_cnt <= 0.
- DECAY, mag < peak: decay_cnt == DECAY_DIV-1 -> apply step, decay_cnt <= 0; else decay_cnt++.
- Decay step: peak <= peak - max(peak >> DECAY_SHIFT, 1); result 0 -> go IDLE.
- IDLE with mag == 0: no change.
- meter_leds[i] = (peak_level >= 128 << i), i = 0..7, computed from the new peak in the same update.
- Clip: mag >= CLIP_THRESH -> clip_led <= 1, clip_cnt <= CLIP_HOLD; non-clipping strobe with clip_cnt != 0 -> decrement; clip_led <= 0 on the strobe where clip_cnt reaches 0.
- Consecutive-cycle strobes are each processed; 3-cycle spacing is not required.

## Timing
- Latency 1: strobe at cycle n -> peak_level, meter_leds, clip_led update and meter_valid high at n+1.
- meter_valid high exactly one cycle per strobe.
- Reset: peak_level 0, meter_leds 0, clip_led 0, meter_valid 0; FSM IDLE; all counters 0. Takes effect immediately, including mid-HOLD or mid-DECAY. Release is synchronous to clk_144, and the first strobe is honoured on the first edge after release.
- Counter widths are sized from the parameters with $clog2 and never wrap; every counter saturates at 0.

## Configuration
- CHANNEL_METER_CLIP_EN defined: clip detection, clip_cnt and clip_led logic compiled in as described.
- Not defined: clip_cnt and the comparator are removed and clip_led is tied 0. Peak, bargraph and meter_valid behaviour are unchanged.

## Test plan
Bench parameters: HOLD_SAMPLES=4, DECAY_DIV=1, DECAY_SHIFT=2, CLIP_THRESH=32000, CLIP_HOLD=3, macro defined unless stated.
- Reset, then strobe 0 -> peak_level 0, meter_leds 0x00, clip_led 0, meter_valid pulses 1 cycle after the strobe.
- Strobe -32768 -> next cycle peak_level 32767, meter_leds 0xFF, clip_led 1. Rerun with macro undefined -> clip_led 0.
- Strobe 16384, then zeros -> peak 16384 (0xFF) for 4 strobes, then 12288 (0x7F), 9216, 6912 on successive strobes.
- Peak 3 in DECAY, zeros -> 2, 1, 0, then IDLE and peak stays 0. Strobe 31999 -> clip_led stays 0.
- Strobe 32000, then zeros -> clip_led 1 through the first two zero strobes, 0 after the third.
- In HOLD at peak 16384, assert reset_n low between edges -> all outputs 0 before the next edge. After release, strobe 200 -> peak 200, meter_leds 0x01.
